reverb_fdn_gen: RTL and testbench
=================================

// Module: reverb_fdn_gen
// PURPOSE
//  Parametrised 4-line feedback-delay-network reverb for the audio loopback path, placed between the codec RX and TX.
//  Per-line delay lengths, runtime feedback gain and wet/dry mix; processes one sample per in_valid strobe, not per clock.
//  Hadamard feedback matrix, saturating arithmetic, post-reset RAM clear.
// PARAMETERS
//  DW   16  sample width, signed two's complement
//  AW   13  delay-RAM address width; every D_i <= 2**AW
//  D0   1151  line-0 delay in samples (>=2)
//  D1   1597  line-1 delay in samples (>=2)
//  D2   2311  line-2 delay in samples (>=2)
//  D3   3001  line-3 delay in samples (>=2)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   audio_in holds a new sample
//  in_ready   out  1   block can accept a sample
//  audio_in   in   DW  dry input sample
//  fb_gain    in   8   feedback gain, unsigned Q0.8 (255 = 0.996)
//  mix        in   8   wet amount, unsigned Q0.8 (0 = dry only)
//  out_valid  out  1   one-cycle pulse: audio_out updated
//  audio_out  out  DW  processed sample, held until next out_valid
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset: in_ready=0, out_valid=0, audio_out=0, all line pointers=0, FSM -> CLEAR. Reset wins over every other event, in any state.
//  FSM:
//   CLEAR: writes 0 to address 0..2**AW-1 of all four lines, one address per cycle. After the last address -> IDLE.
//   IDLE: in_ready=1. in_valid=1 -> latch x, present read address = wptr_i -> RD.
//   RD: RAM read latency 1; d_i is valid at the end of the cycle -> HAD.
//   HAD: register h_k = (±d0±d1±d2±d3)>>>1, using Hadamard rows ++++, +-+-, ++--, +--+.
//     Width DW+2 before the shift, DW+1 after it -> WR.
//   WR: writes v_k = sat(x + ((fb_gain*h_k)>>>8)) at wptr_k.
//     Registers audio_out = sat(((256-mix)*x + mix*((d0+d1+d2+d3)>>>2))>>>8).
//     Advances pointers -> OUT.
//   OUT: out_valid=1 for this cycle only -> IDLE.
//  Latency: a sample accepted in cycle N gives out_valid in cycle N+4. Throughput: 1 sample per 5 cycles.
//  in_ready is 0 outside IDLE. in_valid in those states is ignored (not queued).
//  Read-before-write: the RD address equals the WR address, so line i delays exactly D_i samples.
//  Pointer wrap: wptr_i == D_i-1 -> 0. D_i does not need to be a power of two. Addresses >= D_i are never used after CLEAR.
//  Arithmetic: all products signed. >>> is floor (arithmetic shift). sat() clamps to [-2**(DW-1), 2**(DW-1)-1]; no wrap-around anywhere.
//  mix and fb_gain are sampled in HAD/WR. Changing them mid-sample is legal and takes effect from that cycle.
// CONFIGURATION
//  FDN_DAMPING_EN defined:
//   each line gets a one-pole lowpass in the feedback path: s_k += (h_k - s_k)>>>2, updated in HAD.
//   WR uses s_k instead of h_k. s_k resets to 0.
//  FDN_DAMPING_EN undefined: no filter state; h_k feeds WR directly. Latency is identical in both builds.
// STRUCTURE
//  Package fdn_pkg:
//   FSM state encoding (CLEAR, IDLE, RD, HAD, WR, OUT)
//   function sat(), Hadamard sign table, constant NLINES=4
//  Sub-module fdn_delay_line (instantiated 4x):
//   simple dual-port inferred RAM, DW x 2**AW, 1-cycle read
//   owns the wrap pointer for its D_i; inputs clr_en/clr_addr for CLEAR
// TESTING  (bench: D0..D3 = 5,7,11,13; AW=4)
//  Reset: assert rst for 2 cycles -> audio_out=0, out_valid=0; in_ready=0 for 16 CLEAR cycles, then 1.
//  Dry path: mix=0, fb_gain=0, x=1000 accepted at cycle N -> out_valid at N+4 with audio_out=1000.
//  Impulse: mix=255, fb_gain=0, x=16000 then zeros -> samples 0-4 out=16000/256 then 0, 0, 0, 0; sample 5 out=3984.
//  Saturation: x=32767 sustained, fb_gain=255, mix=128 -> audio_out never negative, clamps at 32767.
//  Handshake: in_valid held high -> exactly one accept per 5 cycles; in_ready=0 in RD/HAD/WR/OUT.
//  Reset mid-sample: rst asserted in HAD -> no out_valid, FSM in CLEAR the next cycle, pointers 0; impulse test passes afterwards.

Source files
------------

// File: rtl/fdn_pkg.sv
// fdn_pkg: FSM encoding, Hadamard sign table and saturation helper shared by the FDN reverb.
package fdn_pkg;
   localparam int NLINES = 4;
   typedef enum logic [2:0] {CLEAR, IDLE, RD, HAD, WR, OUT} state_t;
   // bit i set in row k: d_i is subtracted in Hadamard row k (rows ++++, +-+-, ++--, +--+)
   localparam logic [NLINES-1:0] HSGN [NLINES] = '{4'b0000, 4'b1010, 4'b1100, 4'b0110};
   function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int dw);
      logic signed [31:0] hi;
      hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
      return v > hi ? hi : v < -hi - 32'sd1 ? -hi - 32'sd1 : v;
   endfunction
endpackage

// File: rtl/fdn_delay_line.sv
// fdn_delay_line: one FDN line, simple dual-port RAM with 1-cycle read and its own wrap pointer.
module fdn_delay_line #(
   parameter int DW = 16,
   parameter int AW = 13,
   parameter int D = 1151
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_en,
   input  logic rd_en,
   input  logic wr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wptr;
   always_ff @(posedge clk) begin
      if (clr_en)
         mem[clr_addr] <= '0;
      else if (wr_en)
         mem[wptr] <= wdata;
      if (rd_en)
         rdata <= mem[wptr];
   end
   always_ff @(posedge clk)
      wptr <= rst ? '0 : wr_en ? (wptr == AW'(D - 1) ? '0 : wptr + 1'b1) : wptr;
endmodule

// File: rtl/reverb_fdn_gen.sv
// reverb_fdn_gen: 4-line feedback-delay-network reverb, one sample per in_valid strobe.
// Define FDN_DAMPING_EN to add a one-pole lowpass in each feedback path.
module reverb_fdn_gen
   import fdn_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 13,
   parameter int D0 = 1151,
   parameter int D1 = 1597,
   parameter int D2 = 2311,
   parameter int D3 = 3001
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic [DW-1:0] audio_in,
   input  logic [7:0] fb_gain,
   input  logic [7:0] mix,
   output logic out_valid,
   output logic [DW-1:0] audio_out
);
   localparam int DLEN [NLINES] = '{D0, D1, D2, D3};
   state_t state, state_nx;
   logic [AW-1:0] clr_addr;
   logic signed [DW-1:0] x, avg;
   logic signed [DW-1:0] d [NLINES];
   logic signed [DW-1:0] v [NLINES];
   logic signed [DW+1:0] hs [NLINES];
   logic signed [DW:0] hc [NLINES];
   logic signed [DW:0] fb [NLINES];
   logic signed [DW:0] fb_nx [NLINES];
   logic signed [DW+9:0] fbp [NLINES];
   logic signed [DW+1:0] dsum;
   logic signed [DW+11:0] mixed;
   always_comb begin
      state_nx = state == CLEAR ? (&clr_addr ? IDLE : CLEAR)
               : state == IDLE ? (in_valid ? RD : IDLE)
               : state == RD ? HAD : state == HAD ? WR : state == WR ? OUT : IDLE;
      in_ready = state == IDLE;
      out_valid = state == OUT;
   end
   always_comb begin
      dsum = '0;
      for (int i = 0; i < NLINES; i++)
         dsum = dsum + (DW+2)'(d[i]);
      avg = DW'(dsum >>> 2);
      mixed = (DW+12)'($signed({1'b0, 9'd256 - {1'b0, mix}})) * (DW+12)'(x)
            + (DW+12)'($signed({1'b0, mix})) * (DW+12)'(avg);
      for (int k = 0; k < NLINES; k++) begin
         hs[k] = '0;
         for (int i = 0; i < NLINES; i++)
            hs[k] = HSGN[k][i] ? hs[k] - (DW+2)'(d[i]) : hs[k] + (DW+2)'(d[i]);
         hc[k] = (DW+1)'(hs[k] >>> 1);
`ifdef FDN_DAMPING_EN
         fb_nx[k] = fb[k] + (DW+1)'(((DW+2)'(hc[k]) - (DW+2)'(fb[k])) >>> 2);
`else
         fb_nx[k] = hc[k];
`endif
         fbp[k] = (DW+10)'($signed({1'b0, fb_gain})) * (DW+10)'(fb[k]);
         v[k] = DW'(sat(32'(x) + 32'(fbp[k] >>> 8), DW));
      end
   end
   // fb holds h_k, or the lowpassed s_k when damping is built in
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         clr_addr <= '0;
         x <= '0;
         audio_out <= '0;
         for (int k = 0; k < NLINES; k++)
            fb[k] <= '0;
      end else begin
         state <= state_nx;
         clr_addr <= state == CLEAR ? clr_addr + 1'b1 : clr_addr;
         x <= in_ready && in_valid ? $signed(audio_in) : x;
         for (int k = 0; k < NLINES; k++)
            fb[k] <= state == HAD ? fb_nx[k] : fb[k];
         audio_out <= state == WR ? DW'(sat(32'(mixed >>> 8), DW)) : audio_out;
      end
   end
   for (genvar g = 0; g < NLINES; g++) begin : g_line
      fdn_delay_line #(.DW(DW), .AW(AW), .D(DLEN[g])) u_line (
         .clk(clk),
         .rst(rst),
         .clr_en(state == CLEAR),
         .rd_en(state == RD),
         .wr_en(state == WR),
         .clr_addr(clr_addr),
         .wdata(v[g]),
         .rdata(d[g])
      );
   end
endmodule

// File: tb/tb_reverb_fdn_gen.sv
// tb_reverb_fdn_gen: directed vector bench for reverb_fdn_gen with D = 5,7,11,13 and AW = 4.
module tb_reverb_fdn_gen;
   typedef struct {
      int x;
      int fb;
      int mx;
      int exp;
   } vec_t;
   logic clk = 0, rst = 1, in_valid = 0;
   logic in_ready, out_valid;
   logic [15:0] audio_in = '0, audio_out;
   logic [7:0] fb_gain = '0, mix = '0;
   int errors = 0, checks = 0;
   vec_t vec [49];
   int exp_a [15] = '{62, 0, 0, 0, 0, 3984, 0, 3984, 0, 0, 996, 3984, 1992, 3984, -997};
   int exp_s [15] = '{16383, 16383, 16383, 16383, 16383, 20479, 20479, 24575, 24575, 24575,
                      24575, 28671, 28671, 32767, 32767};
   int exp_i [15] = '{62, 0, 0, 0, 0, 3984, 0, 3984, 0, 0, 0, 3984, 0, 3984, 0};
   int dry [4] = '{1000, -1000, 32767, -32768};

   reverb_fdn_gen #(.DW(16), .AW(4), .D0(5), .D1(7), .D2(11), .D3(13)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .audio_in(audio_in),
      .fb_gain(fb_gain),
      .mix(mix),
      .out_valid(out_valid),
      .audio_out(audio_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!in_ready)
         chk("ready_timeout", n, 0, 1);
   endtask

   task automatic do_reset();
      int n, ov;
      rst = 1;
      in_valid = 0;
      tick();
      tick();
      chk("rst_out_valid", 0, int'(out_valid), 0);
      chk("rst_audio_out", 0, int'($signed(audio_out)), 0);
      chk("rst_in_ready", 0, int'(in_ready), 0);
      rst = 0;
      n = 0;
      ov = 0;
      while (!in_ready && n < 100) begin
         n++;
         ov += int'(out_valid);
         tick();
      end
      chk("clear_cycles", 0, n, 16);
      chk("clear_out_valid", 0, ov, 0);
   endtask

   task automatic do_sample(input int idx);
      int lat;
      wait_ready();
      audio_in = 16'(vec[idx].x);
      fb_gain = 8'(vec[idx].fb);
      mix = 8'(vec[idx].mx);
      in_valid = 1;
      tick();
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", idx, lat, 4);
      chk("audio_out", idx, int'($signed(audio_out)), vec[idx].exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc, busy, ovc, bad, last;
      for (int i = 0; i < 15; i++) begin
         vec[i] = '{i == 0 ? 16000 : 0, 128, 255, exp_a[i]};
         vec[19+i] = '{32767, 255, 128, exp_s[i]};
         vec[34+i] = '{i == 0 ? 16000 : 0, 0, 255, exp_i[i]};
      end
      for (int i = 0; i < 4; i++)
         vec[15+i] = '{dry[i], 0, 0, dry[i]};

      do_reset();
      for (int i = 0; i < 19; i++)
         do_sample(i);

      // handshake: in_valid held high for 40 cycles
      wait_ready();
      audio_in = 16'd123;
      fb_gain = 8'd0;
      mix = 8'd0;
      in_valid = 1;
      acc = 0;
      busy = 0;
      ovc = 0;
      bad = 0;
      last = -1;
      for (int c = 0; c < 40; c++) begin
         if (in_ready) begin
            if (last >= 0 && c - last != 5)
               bad++;
            last = c;
            acc++;
         end else
            busy++;
         ovc += int'(out_valid);
         tick();
      end
      in_valid = 0;
      chk("hs_accepts", 0, acc, 8);
      chk("hs_spacing", 0, bad, 0);
      chk("hs_busy_cycles", 0, busy, 32);
      chk("hs_out_pulses", 0, ovc, 8);

      do_reset();
      for (int i = 19; i < 34; i++)
         do_sample(i);

      // reset asserted while the FSM is in HAD
      wait_ready();
      audio_in = 16'd5000;
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      rst = 1;
      tick();
      chk("mid_out_valid", 0, int'(out_valid), 0);
      chk("mid_in_ready", 0, int'(in_ready), 0);
      chk("mid_audio_out", 0, int'($signed(audio_out)), 0);
      do_reset();
      for (int i = 34; i < 49; i++)
         do_sample(i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
